// File: rtl/router_alloc_pkg.sv
// Shared types for the router switch allocator.
// Index and counter typedefs are sized for the default 5x5 router with 8-deep buffers.
package router_alloc_pkg;

  typedef enum logic {ALLOC_IDLE, ALLOC_LOCKED} alloc_state_t;

  localparam int ROUTE_IDX_W  = 3;
  localparam int IN_IDX_W     = 3;
  localparam int CREDIT_CNT_W = 4;

  typedef logic [ROUTE_IDX_W-1:0]  route_idx_t;
  typedef logic [IN_IDX_W-1:0]     in_idx_t;
  typedef logic [CREDIT_CNT_W-1:0] credit_t;

  localparam int ERR_TURN   = 0;
  localparam int ERR_CREDIT = 1;

endpackage

// File: rtl/router_rr_arbiter.sv
// Round-robin pick of the first request at or after ptr, wrapping.
// Purely combinational; the caller owns the pointer and any backpressure.
module router_rr_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any_grant
);

  always_comb begin
    int c;
    c         = 0;
    gnt       = '0;
    idx       = '0;
    any_grant = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (int'(ptr) + k) % NUM_REQ;
      if (!any_grant && req[c]) begin
        any_grant = 1'b1;
        gnt[c]    = 1'b1;
        idx       = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/router_output_allocator.sv
// Switch allocator with per-output wormhole locking and downstream credit tracking.
// Grants are combinational (pop in the granting cycle); zero credits or a bubbled owner stall the output.
module router_output_allocator
  import router_alloc_pkg::*;
#(
  parameter int NUM_INPUTS        = 5,
  parameter int NUM_OUTPUTS       = 5,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int ROUTE_WIDTH       = 3,
  parameter int IN_IDX_WIDTH      = $clog2(NUM_INPUTS),
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH+1)
) (
  input  logic                                     clk_noc,
  input  logic                                     rst_noc,
  input  logic [NUM_INPUTS-1:0]                    req_valid,
  input  logic [NUM_INPUTS-1:0][ROUTE_WIDTH-1:0]   req_port,
  input  logic [NUM_INPUTS-1:0]                    req_is_tail,
  input  logic [NUM_INPUTS-1:0][NUM_OUTPUTS-1:0]   disable_turns,
  input  logic [NUM_OUTPUTS-1:0]                   credit_in,
  output logic [NUM_INPUTS-1:0]                    grant,
  output logic [NUM_OUTPUTS-1:0]                   out_send,
  output logic [NUM_OUTPUTS-1:0][IN_IDX_WIDTH-1:0] out_sel,
  output logic [NUM_OUTPUTS-1:0]                   out_locked,
  output logic [1:0]                               err_flags
);

  alloc_state_t            state_q  [NUM_OUTPUTS];
  alloc_state_t            state_d  [NUM_OUTPUTS];
  logic [IN_IDX_WIDTH-1:0] owner_q  [NUM_OUTPUTS];
  logic [IN_IDX_WIDTH-1:0] owner_d  [NUM_OUTPUTS];
  logic [IN_IDX_WIDTH-1:0] ptr_q    [NUM_OUTPUTS];
  logic [IN_IDX_WIDTH-1:0] ptr_d    [NUM_OUTPUTS];
  logic [CREDIT_WIDTH-1:0] credit_q [NUM_OUTPUTS];
  logic [CREDIT_WIDTH-1:0] credit_d [NUM_OUTPUTS];
  logic [1:0]              err_q, err_d;

  logic [NUM_INPUTS-1:0]                    owns;
  logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0]   elig;
  logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0]   arb_gnt;
  logic [NUM_OUTPUTS-1:0][IN_IDX_WIDTH-1:0] arb_idx;
  logic [NUM_OUTPUTS-1:0]                   arb_any;
  logic [NUM_OUTPUTS-1:0]                   idle_tail;

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

  function automatic logic [IN_IDX_WIDTH-1:0] next_idx(input logic [IN_IDX_WIDTH-1:0] i);
    return IN_IDX_WIDTH'((int'(i) + 1) % NUM_INPUTS);
  endfunction

  // An input holding a locked output must not compete for any other output.
  always_comb begin
    owns = '0;
    for (int o = 0; o < NUM_OUTPUTS; o++)
      if (state_q[o] == ALLOC_LOCKED) owns[owner_q[o]] = 1'b1;
  end

  always_comb begin
    elig = '0;
    for (int o = 0; o < NUM_OUTPUTS; o++)
      for (int i = 0; i < NUM_INPUTS; i++)
        elig[o][i] = req_valid[i] && (req_port[i] == ROUTE_WIDTH'(o)) &&
                     !disable_turns[i][o] && !owns[i];
  end

  for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_arb
    router_rr_arbiter #(.NUM_REQ(NUM_INPUTS), .IDX_W(IN_IDX_WIDTH)) u_arb (
      .req       (elig[o]),
      .ptr       (ptr_q[o]),
      .gnt       (arb_gnt[o]),
      .idx       (arb_idx[o]),
      .any_grant (arb_any[o])
    );
    assign idle_tail[o] = |(arb_gnt[o] & req_is_tail);
  end

  always_comb begin
    out_send   = '0;
    out_sel    = '0;
    out_locked = '0;
    grant      = '0;
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      if (state_q[o] == ALLOC_LOCKED) begin
        out_locked[o] = 1'b1;
        out_sel[o]    = owner_q[o];
        out_send[o]   = req_valid[owner_q[o]] && (credit_q[o] != '0);
      end else begin
        out_sel[o]    = arb_idx[o];
        out_send[o]   = arb_any[o] && (credit_q[o] != '0);
      end
    end
    if (rst_noc) begin
      out_send   = '0;
      out_locked = '0;
    end
    for (int o = 0; o < NUM_OUTPUTS; o++)
      for (int i = 0; i < NUM_INPUTS; i++)
        if (out_send[o] && (out_sel[o] == IN_IDX_WIDTH'(i))) grant[i] = 1'b1;
  end

  always_comb begin
    logic hit;
    logic bad;
    hit = 1'b0;
    bad = 1'b0;
    err_d = err_q;
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      state_d[o]  = state_q[o];
      owner_d[o]  = owner_q[o];
      ptr_d[o]    = ptr_q[o];
      credit_d[o] = credit_q[o];

      if (out_send[o]) begin
        if (state_q[o] == ALLOC_IDLE) begin
          if (!idle_tail[o]) begin
            state_d[o] = ALLOC_LOCKED;
            owner_d[o] = arb_idx[o];
          end
          ptr_d[o] = next_idx(arb_idx[o]);
        end else if (req_is_tail[owner_q[o]]) begin
          state_d[o] = ALLOC_IDLE;
          ptr_d[o]   = next_idx(owner_q[o]);
        end
      end

      case ({out_send[o], credit_in[o]})
        2'b10:   credit_d[o] = credit_q[o] - 1'b1;
        2'b01: begin
          if (credit_q[o] == CREDIT_FULL) err_d[ERR_CREDIT] = 1'b1;
          else                            credit_d[o] = credit_q[o] + 1'b1;
        end
        default: credit_d[o] = credit_q[o];
      endcase
    end

    for (int i = 0; i < NUM_INPUTS; i++) begin
      hit = 1'b0;
      bad = 1'b0;
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        if (req_port[i] == ROUTE_WIDTH'(o)) begin
          hit = 1'b1;
          if (disable_turns[i][o]) bad = 1'b1;
        end
      end
      if (req_valid[i] && !owns[i] && (bad || !hit)) err_d[ERR_TURN] = 1'b1;
    end
  end

  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        state_q[o]  <= ALLOC_IDLE;
        owner_q[o]  <= '0;
        ptr_q[o]    <= '0;
        credit_q[o] <= CREDIT_FULL;
      end
      err_q <= '0;
    end else begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        state_q[o]  <= state_d[o];
        owner_q[o]  <= owner_d[o];
        ptr_q[o]    <= ptr_d[o];
        credit_q[o] <= credit_d[o];
      end
      err_q <= err_d;
    end
  end

  assign err_flags = err_q;

endmodule

// File: tb/tb_router_output_allocator.sv
// Directed bench for router_output_allocator: reset, credits, round-robin, wormhole, errors, mid-packet reset.
module tb_router_output_allocator;

  logic            clk_noc;
  logic            rst_noc;
  logic [4:0]      req_valid;
  logic [4:0][2:0] req_port;
  logic [4:0]      req_is_tail;
  logic [4:0][4:0] disable_turns;
  logic [4:0]      credit_in;
  logic [4:0]      grant;
  logic [4:0]      out_send;
  logic [4:0][2:0] out_sel;
  logic [4:0]      out_locked;
  logic [1:0]      err_flags;

  int n_vec;
  int n_err;
  int gcount;

  router_output_allocator dut (
    .clk_noc       (clk_noc),
    .rst_noc       (rst_noc),
    .req_valid     (req_valid),
    .req_port      (req_port),
    .req_is_tail   (req_is_tail),
    .disable_turns (disable_turns),
    .credit_in     (credit_in),
    .grant         (grant),
    .out_send      (out_send),
    .out_sel       (out_sel),
    .out_locked    (out_locked),
    .err_flags     (err_flags)
  );

  initial clk_noc = 1'b0;
  always #5 clk_noc = ~clk_noc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_inputs();
    req_valid     = '0;
    req_port      = '0;
    req_is_tail   = '0;
    disable_turns = '0;
    credit_in     = '0;
  endtask

  initial begin
    logic [4:0] wh_valid0, wh_tail0, wh_grant, wh_lock;
    n_vec = 0;
    n_err = 0;
    clr_inputs();
    rst_noc = 1'b1;

    // Reset: outputs forced low even with a live request
    @(negedge clk_noc);
    req_valid[1] = 1'b1; req_port[1] = 3'd1; req_is_tail[1] = 1'b1;
    #1;
    chk("rst_grant",  grant,      0);
    chk("rst_send",   out_send,   0);
    chk("rst_locked", out_locked, 0);
    chk("rst_err",    err_flags,  0);

    @(negedge clk_noc);
    rst_noc = 1'b0;
    req_valid = '0;
    #1;
    chk("idle_send",   out_send,   0);
    chk("idle_locked", out_locked, 0);

    // Ten single-flit packets, no returned credits: eight go, two stall
    gcount = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_noc);
      req_valid[1] = 1'b1;
      #1;
      chk("fill_grant", grant, (k < 8) ? 5'b00010 : 5'b00000);
      gcount += int'(grant[1]);
    end
    chk("fill_count", gcount, 8);

    @(negedge clk_noc);
    credit_in[1] = 1'b1;
    #1 chk("zero_credit_stall", grant, 0);
    @(negedge clk_noc);
    credit_in[1] = 1'b0;
    #1 chk("one_credit_grant", grant, 5'b00010);
    @(negedge clk_noc);
    #1 chk("one_credit_stall", grant, 0);

    @(negedge clk_noc);
    req_valid[1] = 1'b0; credit_in[1] = 1'b1;
    @(negedge clk_noc);
    req_valid[1] = 1'b1; credit_in[1] = 1'b1;
    #1 chk("send_and_credit", grant, 5'b00010);
    @(negedge clk_noc);
    credit_in[1] = 1'b0;
    #1 chk("credit_unchanged", grant, 5'b00010);
    @(negedge clk_noc);
    #1 chk("credit_unchanged_stall", grant, 0);

    // Contention on output 2 with a credit back every cycle
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_noc);
      clr_inputs();
      req_valid[1] = 1'b1; req_port[1] = 3'd2; req_is_tail[1] = 1'b1;
      req_valid[3] = 1'b1; req_port[3] = 3'd2; req_is_tail[3] = 1'b1;
      credit_in[2] = 1'b1;
      #1;
      chk("rr_grant", grant, (k % 2 == 1) ? 5'b01000 : 5'b00010);
      chk("rr_sel", out_sel[2], (k % 2 == 1) ? 3 : 1);
    end

    // Wormhole: input 0 holds output 4 for head, body, tail; input 2 waits
    wh_valid0 = 5'b00111;
    wh_tail0  = 5'b00100;
    wh_lock   = 5'b00110;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_noc);
      clr_inputs();
      req_valid[0] = wh_valid0[k]; req_port[0] = 3'd4; req_is_tail[0] = wh_tail0[k];
      req_valid[2] = 1'b1;         req_port[2] = 3'd4; req_is_tail[2] = 1'b1;
      wh_grant = (k < 3) ? 5'b00001 : 5'b00100;
      #1;
      chk("wh_grant", grant, wh_grant);
      chk("wh_locked", out_locked[4], wh_lock[k]);
    end

    // Forbidden turn never granted and flags the error
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_noc);
      clr_inputs();
      disable_turns[3][3] = 1'b1;
      req_valid[3] = 1'b1; req_port[3] = 3'd3; req_is_tail[3] = 1'b1;
      #1 chk("turn_blocked", grant, 0);
    end
    @(negedge clk_noc);
    clr_inputs();
    #1 chk("turn_err", err_flags, 2'b01);

    // Credit overflow on a full output; counter must stay at 8
    @(negedge clk_noc);
    credit_in[0] = 1'b1;
    @(negedge clk_noc);
    credit_in[0] = 1'b0;
    #1 chk("overflow_err", err_flags, 2'b11);
    gcount = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_noc);
      req_valid[0] = 1'b1; req_port[0] = 3'd0; req_is_tail[0] = 1'b1;
      #1 gcount += int'(grant[0]);
    end
    chk("overflow_count", gcount, 8);

    // Asynchronous reset in the middle of a packet
    @(negedge clk_noc);
    clr_inputs();
    req_valid[0] = 1'b1; req_port[0] = 3'd4; req_is_tail[0] = 1'b0;
    req_valid[2] = 1'b1; req_port[2] = 3'd4; req_is_tail[2] = 1'b1;
    #1 chk("mp_head", grant, 5'b00001);
    @(negedge clk_noc);
    #1 chk("mp_locked", out_locked, 5'b10000);
    #2;
    rst_noc = 1'b1;
    req_valid[0] = 1'b0;
    #1;
    chk("mp_rst_locked", out_locked, 0);
    chk("mp_rst_grant",  grant,      0);
    chk("mp_rst_err",    err_flags,  0);
    @(negedge clk_noc);
    rst_noc = 1'b0;
    #1;
    chk("mp_after_grant",  grant,      5'b00100);
    chk("mp_after_sel",    out_sel[4], 2);
    chk("mp_after_locked", out_locked, 0);

    @(negedge clk_noc);
    clr_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
